// File: rtl/invol_arb_pkg.sv
// invol_arb_pkg -- shared types and constants for the involuntary-message arbiter.
//   state_t : arbiter FSM states
//   PARAM_W : width of one parameter word
//   idx_w() : index width needed to address n requesters (minimum 1)
package invol_arb_pkg;

  localparam int PARAM_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_UP,
    S_GRANTED,
    S_RELEASE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/invol_arb_rr_pick.sv
// rr_pick -- combinational round-robin priority encoder.
//   i_req   : request vector
//   i_ptr   : search start position (must be < NREQ)
//   o_idx   : first set request at or above i_ptr, wrapping modulo NREQ
//   o_valid : any request set
module rr_pick
  import invol_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Rotating the doubled vector puts unit ptr at bit 0, so a plain
  // lowest-set-bit search over w_rot is the round-robin search.
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;

  assign w_dbl   = {i_req, i_req};
  assign w_rot   = w_dbl[i_ptr +: NREQ];
  assign o_valid = |i_req;

  always_comb begin
    o_idx = '0;
    // Walk from the top so the lowest rotated position is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_idx = (int'(i_ptr) + k >= NREQ) ? IDX_W'(int'(i_ptr) + k - NREQ)
                                          : IDX_W'(int'(i_ptr) + k);
      end
    end
  end

endmodule

// File: rtl/invol_arb.sv
// invol_arb -- arbitrates NREQ units onto one upstream involuntary-message
// channel and muxes the winner's parameter words to the upstream framer.
//   clk, rst_n                      : clock, async active-low reset
//   unit_req / unit_grant           : per-unit level request / one-hot grant
//   unit_param_data/_write          : per-unit parameter word and strobe
//   param_data / param_write        : winner's word/strobe while granted, else 0
//   invol_req / invol_grant         : upstream handshake
//   timeout_evt                     : forced-release pulse (INVOL_TIMEOUT_EN only)
// Build option: define INVOL_TIMEOUT_EN to bound a grant to MAX_HOLD cycles.
module invol_arb
  import invol_arb_pkg::*;
#(
  parameter int          NREQ     = 4,
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         unit_req,
  output logic [NREQ-1:0]         unit_grant,
  input  logic [NREQ*PARAM_W-1:0] unit_param_data,
  input  logic [NREQ-1:0]         unit_param_write,
  output logic [PARAM_W-1:0]      param_data,
  output logic                    param_write,
  output logic                    invol_req,
  input  logic                    invol_grant
`ifdef INVOL_TIMEOUT_EN
  ,
  output logic                    timeout_evt
`endif
);

  localparam int IDX_W = idx_w(NREQ);

  if (NREQ < 2 || NREQ > 16 || MAX_HOLD == 0) begin : g_bad_cfg
    $error("invol_arb: NREQ must be 2..16 and MAX_HOLD nonzero");
  end

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_winner;
  logic [NREQ-1:0]   r_grant;
  logic              r_invol_req;

  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_vld;
  logic              w_win_req;
  logic              w_granted;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic              w_timeout;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .i_req   (unit_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_win_req = unit_req[r_winner];
  assign w_granted = |r_grant;
  assign w_ptr_nxt = (r_winner == IDX_W'(NREQ - 1)) ? '0 : r_winner + 1'b1;

`ifdef INVOL_TIMEOUT_EN
  logic [31:0] r_hold_cnt;
  logic        r_timeout_evt;
  // Grant is visible from the cycle GRANTED is entered, so release on the
  // count of MAX_HOLD-1 leaves unit_grant high for exactly MAX_HOLD cycles.
  assign w_timeout   = (r_hold_cnt == 32'(MAX_HOLD - 1));
  assign timeout_evt = r_timeout_evt;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_winner    <= '0;
      r_grant     <= '0;
      r_invol_req <= 1'b0;
`ifdef INVOL_TIMEOUT_EN
      r_hold_cnt    <= '0;
      r_timeout_evt <= 1'b0;
`endif
    end else begin
`ifdef INVOL_TIMEOUT_EN
      r_timeout_evt <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_winner    <= w_pick_idx;
            r_invol_req <= 1'b1;
            r_state     <= S_WAIT_UP;
          end
        end
        S_WAIT_UP: begin
          // A withdrawn request wins over an upstream grant; ptr stays put
          // so the same search order is retried.
          if (!w_win_req) begin
            r_invol_req <= 1'b0;
            r_state     <= S_RELEASE;
          end else if (invol_grant) begin
            r_grant <= NREQ'(1) << r_winner;
            r_state <= S_GRANTED;
          end
        end
        S_GRANTED: begin
          if (!w_win_req || !invol_grant || w_timeout) begin
            r_grant     <= '0;
            r_invol_req <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_state     <= S_RELEASE;
`ifdef INVOL_TIMEOUT_EN
            r_hold_cnt    <= '0;
            // Only flag releases that the counter actually forced.
            r_timeout_evt <= w_timeout & w_win_req & invol_grant;
          end else begin
            r_hold_cnt <= r_hold_cnt + 32'd1;
`endif
          end
        end
        S_RELEASE: begin
          if (!invol_grant) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign unit_grant  = r_grant;
  assign invol_req   = r_invol_req;
  assign param_data  = w_granted ? unit_param_data[int'(r_winner)*PARAM_W +: PARAM_W] : '0;
  assign param_write = w_granted & unit_param_write[r_winner];

endmodule

// File: tb/tb_invol_arb.sv
`timescale 1ns/1ps
module tb_invol_arb;
  import invol_arb_pkg::*;

  localparam int          NREQ = 4;
  localparam int unsigned MAXH = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         unit_req;
  logic [NREQ-1:0]         unit_grant;
  logic [NREQ*PARAM_W-1:0] unit_param_data;
  logic [NREQ-1:0]         unit_param_write;
  logic [PARAM_W-1:0]      param_data;
  logic                    param_write;
  logic                    invol_req;
  logic                    invol_grant = 1'b0;
`ifdef INVOL_TIMEOUT_EN
  logic                    timeout_evt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_tmo  = 0;
  int up_delay = 3;
  int up_cnt   = 0;

  logic [PARAM_W-1:0] q_param[$];
  int                 q_grant[$];
  logic [PARAM_W-1:0] mon_pexp;
  int                 mon_gexp;
  logic [NREQ-1:0]    prev_grant = '0;

  always #5 clk = ~clk;

  invol_arb #(.NREQ(NREQ), .MAX_HOLD(MAXH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .unit_req         (unit_req),
    .unit_grant       (unit_grant),
    .unit_param_data  (unit_param_data),
    .unit_param_write (unit_param_write),
    .param_data       (param_data),
    .param_write      (param_write),
    .invol_req        (invol_req),
    .invol_grant      (invol_grant)
`ifdef INVOL_TIMEOUT_EN
    ,
    .timeout_evt      (timeout_evt)
`endif
  );

  // Upstream model: grants up_delay cycles after invol_req, drops with it.
  always @(negedge clk) begin
    if (!invol_req) begin
      invol_grant = 1'b0;
      up_cnt      = 0;
    end else if (!invol_grant) begin
      up_cnt++;
      if (up_cnt >= up_delay) invol_grant = 1'b1;
    end
  end

  // Scoreboard monitor: param writes and grant order popped as they appear.
  always @(posedge clk) begin
    #1;
    if (param_write) begin
      n_chk++;
      if (q_param.size() == 0) begin
        n_fail++;
        $display("FAIL param_unexpected: got data=%h, no write expected", param_data);
      end else begin
        mon_pexp = q_param.pop_front();
        if (param_data !== mon_pexp) begin
          n_fail++;
          $display("FAIL param_data: got %h, expected %h", param_data, mon_pexp);
        end
      end
    end
    if (unit_grant != '0 && prev_grant == '0) begin
      n_chk++;
      if (q_grant.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got %b, no grant expected", unit_grant);
      end else begin
        mon_gexp = q_grant.pop_front();
        if (unit_grant !== (NREQ'(1) << mon_gexp)) begin
          n_fail++;
          $display("FAIL grant_order: got %b, expected unit %0d", unit_grant, mon_gexp);
        end
      end
    end
    n_chk++;
    if ($countones(unit_grant) > 1 || (unit_grant != '0 && invol_req !== 1'b1)) begin
      n_fail++;
      $display("FAIL grant_invariant: grant=%b invol_req=%b, required one-hot under invol_req",
               unit_grant, invol_req);
    end
`ifdef INVOL_TIMEOUT_EN
    if (timeout_evt) n_tmo++;
`endif
    prev_grant = unit_grant;
  end

  task automatic do_reset();
    rst_n            = 1'b0;
    unit_req         = '0;
    unit_param_write = '0;
    unit_param_data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (unit_grant[i]) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL grant_wait unit %0d: grant=%b after 40 cycles, required bit set", i, unit_grant);
    end
  endtask

  // Waits for unit i's grant, streams nw words base*(w+1), then drops req.
  task automatic serve_unit(input int i, input int nw, input logic [31:0] base, input int rereq);
    bit ok;
    wait_grant(i, ok);
    if (rereq >= 0) unit_req[rereq] = 1'b1;
    for (int w = 0; w < nw; w++) begin
      if (w > 0) @(negedge clk);
      unit_param_data[i*PARAM_W +: PARAM_W] = base * (w + 1);
      unit_param_write[i] = 1'b1;
      q_param.push_back(base * (w + 1));
    end
    @(negedge clk);
    unit_param_write[i] = 1'b0;
    unit_req[i]         = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (unit_grant !== '0 || invol_req !== 1'b0) begin
      n_fail++;
      $display("FAIL release_latency unit %0d: grant=%b invol_req=%b, required 0/0", i, unit_grant, invol_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    unit_req = '0; unit_param_write = '0; unit_param_data = '0;
    #3;
    n_chk++;
    if (unit_grant !== '0 || invol_req !== 1'b0 || param_write !== 1'b0 || param_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b req=%b pw=%b pd=%h, required all 0",
               unit_grant, invol_req, param_write, param_data);
    end
    n_chk++;
    if (dut.r_state !== S_IDLE || dut.r_ptr !== '0 || dut.r_winner !== '0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d ptr=%0d winner=%0d, required 0/0/0",
               dut.r_state, dut.r_ptr, dut.r_winner);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    up_delay = 3;
    @(negedge clk);
    unit_req[2] = 1'b1;
    q_grant.push_back(2);
    // A stray strobe from a unit that is never granted must be dropped.
    unit_param_data[0*PARAM_W +: PARAM_W] = 32'hDEAD_BEEF;
    unit_param_write[0] = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (invol_req !== 1'b1 || unit_grant !== '0) begin
      n_fail++;
      $display("FAIL req_latency: invol_req=%b grant=%b, required 1/0", invol_req, unit_grant);
    end
    serve_unit(2, 3, 32'h11, -1);
    unit_param_write[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (dut.r_ptr !== 2'd3 || dut.r_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL single_ptr: ptr=%0d state=%0d, required 3/IDLE", dut.r_ptr, dut.r_state);
    end
  endtask

  task automatic test_order();
    do_reset();
    up_delay = 2;
    @(negedge clk);
    unit_req = 4'b1011;
    q_grant.push_back(0); q_grant.push_back(1); q_grant.push_back(3); q_grant.push_back(0);
    serve_unit(0, 1, 32'hA0, -1);
    serve_unit(1, 2, 32'hB0, 0);
    serve_unit(3, 1, 32'hC0, -1);
    serve_unit(0, 1, 32'hD0, -1);
    repeat (3) @(negedge clk);
    n_chk++;
    if (q_grant.size() != 0 || dut.r_ptr !== 2'd1) begin
      n_fail++;
      $display("FAIL order_done: pending grants=%0d ptr=%0d, required 0/1", q_grant.size(), dut.r_ptr);
    end
  endtask

  task automatic test_abort();
    logic [1:0] p;
    up_delay = 20;
    @(negedge clk);
    unit_req[1] = 1'b1;
    @(posedge clk); #1;
    p = dut.r_ptr;
    n_chk++;
    if (invol_req !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_req: invol_req=%b, required 1", invol_req);
    end
    @(negedge clk);
    unit_req[1] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (invol_req !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_drop: invol_req=%b, required 0", invol_req);
    end
    @(posedge clk); #1;
    n_chk++;
    if (dut.r_state !== S_IDLE || dut.r_ptr !== p) begin
      n_fail++;
      $display("FAIL abort_idle: state=%0d ptr=%0d, required IDLE/%0d", dut.r_state, dut.r_ptr, p);
    end
  endtask

`ifdef INVOL_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int hi;
    int t0;
    do_reset();
    up_delay = 2;
    t0 = n_tmo;
    @(negedge clk);
    unit_req = 4'b0011;
    q_grant.push_back(0); q_grant.push_back(1);
    wait_grant(0, ok);
    hi = ok ? 1 : 0;
    for (int c = 0; c < 50 && ok; c++) begin
      @(negedge clk);
      if (unit_grant[0]) hi++;
      else break;
    end
    n_chk++;
    if (hi != int'(MAXH)) begin
      n_fail++;
      $display("FAIL timeout_hold: grant held %0d cycles, required %0d", hi, MAXH);
    end
    unit_req[0] = 1'b0;
    serve_unit(1, 0, 32'h0, -1);
    n_chk++;
    if (n_tmo - t0 != 1) begin
      n_fail++;
      $display("FAIL timeout_evt: %0d pulses, required 1", n_tmo - t0);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    up_delay = 1;
    @(negedge clk);
    unit_req[3] = 1'b1;
    q_grant.push_back(3);
    wait_grant(3, ok);
    unit_param_data[3*PARAM_W +: PARAM_W] = 32'h5A;
    unit_param_write[3] = 1'b1;
    q_param.push_back(32'h5A);
    @(negedge clk);
    unit_param_data[3*PARAM_W +: PARAM_W] = 32'h5B;
    q_param.push_back(32'h5B);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (unit_grant !== '0 || invol_req !== 1'b0 || param_write !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: grant=%b req=%b pw=%b, required 0/0/0", unit_grant, invol_req, param_write);
    end
    unit_req = 4'b1010;
    repeat (2) @(negedge clk);
    n_chk++;
    if (dut.r_ptr !== '0 || dut.r_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_ptr: ptr=%0d state=%0d, required 0/IDLE", dut.r_ptr, dut.r_state);
    end
    rst_n = 1'b1;
    q_grant.push_back(1); q_grant.push_back(3);
    serve_unit(1, 1, 32'h77, -1);
    unit_param_write[3] = 1'b0;
    serve_unit(3, 1, 32'h99, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_order();
    test_abort();
`ifdef INVOL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    repeat (4) @(negedge clk);
    n_chk++;
    if (q_grant.size() != 0 || q_param.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: grants left=%0d params left=%0d, required 0/0",
               q_grant.size(), q_param.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
